// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, debounce and key-press events.
// Ports: CLK, RST_N, ROW_IN[3:0] in; COL_OUT, KEY_CODE, KEY_VALID, KEY_DOWN, MULTI out.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] ROW_IN,
  output logic [3:0] COL_OUT,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_DOWN,
  output logic       MULTI
);

  function automatic logic onehot16(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  logic [7:0]  div_q, div_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  sync1_q, sync2_q;
  logic [15:0] work_q, work_d;
  logic [15:0] prev_q, prev_d;
  logic [3:0]  stable_q, stable_d;
  logic [15:0] acc_q, acc_d;
  logic        evt_q, evt_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, down_q, multi_q;
  logic        last_dwell, scan_end;
  logic        acc_one;
  logic [3:0]  acc_idx;

  assign COL_OUT   = 4'b0001 << col_q;
  assign KEY_CODE  = code_q;
  assign KEY_VALID = valid_q;
  assign KEY_DOWN  = down_q;
  assign MULTI     = multi_q;

  assign last_dwell = (div_q == 8'(SCAN_DIV - 1));
  assign scan_end   = last_dwell && (col_q == 2'd3);
  assign acc_one    = onehot16(acc_q);

  always_comb begin
    acc_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (acc_q[i]) acc_idx = 4'(i);
    end
  end

  always_comb begin
    div_d    = last_dwell ? 8'd0 : div_q + 8'd1;
    col_d    = last_dwell ? col_q + 2'd1 : col_q;
    work_d   = work_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    acc_d    = acc_q;
    evt_d    = 1'b0;
    if (last_dwell) begin
      for (int r = 0; r < 4; r++) begin
        work_d[{2'(r), col_q}] = sync2_q[r];
      end
    end
    if (scan_end) begin
      if (work_d == prev_q) begin
        stable_d = (stable_q == 4'(DEBOUNCE_SCANS))
                 ? stable_q : stable_q + 4'd1;
      end else begin
        stable_d = 4'd1;
        prev_d   = work_d;
      end
      if (stable_d == 4'(DEBOUNCE_SCANS) && work_d != acc_q) begin
        acc_d = work_d;
        // events only on a clean idle-to-single-key transition
        evt_d = (acc_q == 16'd0) && onehot16(work_d);
      end
    end
  end

  assign code_d = acc_one ? acc_idx : code_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q    <= 8'd0;
      col_q    <= 2'd0;
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      work_q   <= 16'd0;
      prev_q   <= 16'd0;
      stable_q <= 4'd0;
      acc_q    <= 16'd0;
      evt_q    <= 1'b0;
      code_q   <= 4'd0;
      valid_q  <= 1'b0;
      down_q   <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      col_q    <= col_d;
      sync1_q  <= ROW_IN;
      sync2_q  <= sync1_q;
      work_q   <= work_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      acc_q    <= acc_d;
      evt_q    <= evt_d;
      code_q   <= code_d;
      valid_q  <= evt_q;
      down_q   <= acc_one;
      multi_q  <= (acc_q != 16'd0) && !acc_one;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner.
// Two instances: default timing and the slow-scan single-debounce corner.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = 16'd0;
  logic [15:0] keys2 = 16'd0;
  logic [3:0]  row, row2;
  logic [3:0]  col, col2;
  logic [3:0]  kc, kc2;
  logic        kv, kv2, kd, kd2, km, km2;

  int n_chk = 0;
  int n_pass = 0;
  int vcnt = 0;
  int vcnt2 = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] kp(input logic [15:0] k,
                                    input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = |(k[i*4 +: 4] & c);
    return r;
  endfunction

  assign row  = kp(keys, col);
  assign row2 = kp(keys2, col2);

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) u_dut (
    .CLK(clk), .RST_N(rst_n), .ROW_IN(row), .COL_OUT(col),
    .KEY_CODE(kc), .KEY_VALID(kv), .KEY_DOWN(kd), .MULTI(km)
  );

  keypad_scanner #(.SCAN_DIV(255), .DEBOUNCE_SCANS(1)) u_big (
    .CLK(clk), .RST_N(rst_n), .ROW_IN(row2), .COL_OUT(col2),
    .KEY_CODE(kc2), .KEY_VALID(kv2), .KEY_DOWN(kd2), .MULTI(km2)
  );

  always @(negedge clk) begin
    if (kv) vcnt++;
    if (kv2) vcnt2++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] c);
    int n = 0;
    while (col != c && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("align", col, c);
  endtask

  task automatic wait_pulse(input int budget, input bit big,
                            output int cyc, output logic seen);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      seen = big ? kv2 : kv;
    end
  endtask

  initial begin
    int v0, cyc, n;
    logic seen;
    logic [3:0] e, c;
    logic bad;

    repeat (3) @(negedge clk);
    chk("rst col", col, 4'b0001);
    chk("rst code", kc, 4'd0);
    chk("rst flags", {kv, kd, km}, 3'b000);
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e = 4'b0001 << (((k + 1) / 4) % 4);
      chk("col seq", col, e);
    end
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (kv || kd || km) bad = 1'b1;
    end
    chk("idle quiet", bad, 1'b0);

    // single press of key 6 at the start of the column-2 dwell
    wait_col(4'b0010);
    wait_col(4'b0100);
    v0 = vcnt;
    keys[6] = 1'b1;
    wait_pulse(60, 1'b0, cyc, seen);
    chk("k6 pulse", seen, 1'b1);
    chk("k6 latency", cyc <= 51, 1'b1);
    chk("k6 code", kc, 4'd6);
    scans(4);
    chk("k6 count", vcnt - v0, 1);
    chk("k6 down", kd, 1'b1);
    chk("k6 multi", km, 1'b0);
    keys = 16'd0;
    scans(4);
    chk("k6 up", kd, 1'b0);
    chk("k6 no rel pulse", vcnt - v0, 1);

    // chatter on key 0, one scan on / one scan off
    wait_col(4'b1000);
    wait_col(4'b0001);
    v0 = vcnt;
    for (int i = 0; i < 6; i++) begin
      keys[0] = (i % 2 == 0);
      scans(1);
    end
    keys = 16'd0;
    scans(2);
    chk("bounce none", vcnt - v0, 0);
    chk("bounce down", kd, 1'b0);
    keys[0] = 1'b1;
    wait_pulse(60, 1'b0, cyc, seen);
    chk("k0 pulse", seen, 1'b1);
    chk("k0 code", kc, 4'd0);
    scans(2);
    chk("k0 count", vcnt - v0, 1);
    keys = 16'd0;
    scans(4);

    // two keys, then one released
    v0 = vcnt;
    keys = 16'h0420;
    scans(5);
    chk("multi m", km, 1'b1);
    chk("multi d", kd, 1'b0);
    chk("multi code", kc, 4'd0);
    chk("multi none", vcnt - v0, 0);
    keys[10] = 1'b0;
    scans(4);
    chk("m2one m", km, 1'b0);
    chk("m2one d", kd, 1'b1);
    chk("m2one code", kc, 4'd5);
    chk("m2one none", vcnt - v0, 0);
    keys = 16'd0;
    scans(4);
    chk("m rel", kd, 1'b0);
    keys[15] = 1'b1;
    wait_pulse(60, 1'b0, cyc, seen);
    chk("k15 pulse", seen, 1'b1);
    chk("k15 code", kc, 4'd15);
    keys = 16'd0;
    scans(4);

    // reset while key 3 is held
    keys[3] = 1'b1;
    wait_pulse(60, 1'b0, cyc, seen);
    chk("k3 pulse", seen, 1'b1);
    chk("k3 code", kc, 4'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst col", col, 4'b0001);
    chk("mid rst code", kc, 4'd0);
    chk("mid rst flags", {kv, kd, km}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(60, 1'b0, cyc, seen);
    chk("k3 again", seen, 1'b1);
    chk("k3 again code", kc, 4'd3);
    keys = 16'd0;
    scans(4);

    // slow scan, single debounce scan
    c = col2;
    n = 0;
    while (col2 == c && n < 600) begin
      @(negedge clk);
      n++;
    end
    c = col2;
    n = 0;
    while (col2 == c && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("dwell 255", n, 255);
    keys2[12] = 1'b1;
    wait_pulse(2100, 1'b1, cyc, seen);
    chk("k12 pulse", seen, 1'b1);
    chk("k12 latency", cyc <= 2043, 1'b1);
    chk("k12 code", kc2, 4'd12);
    @(negedge clk);
    chk("k12 down", kd2, 1'b1);
    chk("k12 count", vcnt2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reader side of the one-hot column scan used for the machine's front panel.
- Drives a 4-column one-hot scan onto the drink-selection keypad and senses 4 row lines.
- Debounces the full 16-key matrix and reports a single key-press event (code plus one-cycle valid pulse) to the main coffee-machine controller.
- Sits between the keypad pins and the controller FSM.

Parameters:
- SCAN_DIV, 4: clock cycles each column is held active; legal range 4..255.
- DEBOUNCE_SCANS, 2: consecutive identical full-matrix scans required before a change is accepted; legal range 1..15.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ROW_IN  input  4  raw keypad row lines, active-high, asynchronous to CLK.
- COL_OUT  output  4  one-hot column drive, active-high.
- KEY_CODE  output  4  index of the accepted key, row*4+col.
- KEY_VALID  output  1  one-cycle pulse per accepted press.
- KEY_DOWN  output  1  high while exactly one key is held in the accepted state.
- MULTI  output  1  high while the accepted state has more than one key pressed.

Behaviour:
- Reset (async, RST_N=0):
  - COL_OUT=4'b0001; KEY_CODE=0; KEY_VALID=0; KEY_DOWN=0; MULTI=0.
  - Dwell counter, column index, snapshot, stable count and accepted state all cleared.
  - Deassertion is taken synchronously; scanning starts at column 0 on the first edge after release.
- Column sequence: column index 0,1,2,3,0,... with COL_OUT = 0001, 0010, 0100, 1000 respectively. Each column is held exactly SCAN_DIV cycles; a full scan is 4*SCAN_DIV cycles.
- ROW_IN synchronisation: two-flop synchroniser, so 2 cycles of latency.
- Row sampling: the synchronised rows are sampled on the last dwell cycle of each column (dwell counter = SCAN_DIV-1). They are written into bits [row*4+col] of a 16-bit working snapshot.
- Scan completion: at the end of the column-3 dwell, the working snapshot is complete and is compared with the previous full snapshot.
  - Equal: stable count increments, saturating at DEBOUNCE_SCANS.
  - Different: stable count is set to 1, and the previous-snapshot register takes the new value.
- Acceptance: when stable count reaches DEBOUNCE_SCANS and the snapshot differs from the accepted state, the accepted state is loaded on that same edge.
- Outputs from accepted state, updated the cycle after the accepted state changes:
  - Exactly one bit set: KEY_DOWN=1, MULTI=0, KEY_CODE = index of that bit.
  - Two or more bits set: MULTI=1, KEY_DOWN=0, KEY_CODE holds its last value.
  - Zero bits set: KEY_DOWN=0, MULTI=0, KEY_CODE holds.
- KEY_VALID:
  - Pulses for exactly one cycle, together with the KEY_CODE update, only when the accepted state goes from all-zero to exactly one key.
  - No pulse for held keys (no auto-repeat).
  - No pulse on a transition from multiple keys down to one key. Every key must be released (accepted all-zero) before the next event.
  - No pulse on a one-key to different-one-key transition without an intervening all-zero accepted state.
- Bounce: any snapshot change restarts the stable count. Chatter shorter than DEBOUNCE_SCANS full scans never reaches the accepted state.
- Latency: a clean press held from before a scan starts is accepted at the end of scan DEBOUNCE_SCANS. KEY_VALID follows 1 cycle later. Worst case from press to pulse is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- Reset mid-operation: all state is cleared immediately and outputs return to their reset values. A key held across reset produces a fresh KEY_VALID after re-debounce.
- Counter widths: dwell counter 8 bits, stable count 4 bits. The column index wraps 3 to 0 naturally.

Test Plan:
- Reset/scan: release RST_N with ROW_IN=0 and SCAN_DIV=4.
  - Required: COL_OUT cycles 0001, 0010, 0100, 1000 for 4 cycles each and repeats.
  - Required: KEY_VALID, KEY_DOWN and MULTI stay 0 for 200 cycles.
- Single press: assert ROW_IN[1] while COL_OUT[2]=1, held for 5 scans.
  - Required: exactly one KEY_VALID pulse with KEY_CODE=6, within 51 cycles of press start.
  - Required: KEY_DOWN=1 until release; after release is debounced, KEY_DOWN returns to 0 with no pulse.
- Bounce: toggle key 0 (row0/col0) on alternate scans for 6 scans, then release.
  - Required: no KEY_VALID.
  - Then hold it for 3 scans. Required: one pulse with KEY_CODE=0.
- Multi-key: hold keys 5 and 10 together, then release key 10 only.
  - Required: MULTI=1 and no pulse while both are held.
  - Required: after key 10 is released, MULTI=0, KEY_DOWN=1 and still no pulse.
  - Release all, then press key 15. Required: pulse with KEY_CODE=15.
- Reset mid-press: hold key 3, wait for its pulse, then drop RST_N for 3 cycles.
  - Required: outputs at reset values immediately, COL_OUT=0001.
  - Required: after release, a second KEY_VALID with KEY_CODE=3.
- Parameter corner: SCAN_DIV=255, DEBOUNCE_SCANS=1, press key 12.
  - Required: each column dwell is 255 cycles.
  - Required: pulse with KEY_CODE=12 no later than 2043 cycles after press.
